msg_checker: RTL
================

MSG_CHECKER -- requirements
Module: msg_checker

Interface
REQ-001 The module SHALL have parameter MSG_LEN, default 32, giving the number of decrypted-message bytes scanned (1..32).
REQ-002 The module SHALL have parameter ADDR_W, default 5, giving the width of the decrypted-message RAM address.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge clocked on clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to scan the message; sampled only in IDLE.
REQ-006 q_d  input  8  read data from the decrypted-message RAM.
REQ-007 address_d  output  ADDR_W  read address to the decrypted-message RAM, driven from a register.
REQ-008 mem_req  output  1  request for RAM ownership from the memory router; high while the scan runs.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 finish  output  1  single-cycle pulse marking that the results are valid.
REQ-011 key_valid  output  1  high when all MSG_LEN bytes are legal characters.
REQ-012 bad_index  output  ADDR_W  index of the first illegal byte; 0 if there is none.
REQ-013 bad_count  output  6  number of illegal bytes found.

Function
REQ-014 A legal byte SHALL be 0x20 (space) or 0x61..0x7A ('a'..'z'); every other value is illegal.
REQ-015 The FSM states SHALL be IDLE, ADDR, WAIT, CHECK and DONE.
REQ-016 IDLE SHALL move to ADDR when start=1, clear bad_count, bad_index and key_valid, and set index k=0.
REQ-017 ADDR SHALL drive address_d=k and move to WAIT.
REQ-018 WAIT SHALL move to CHECK, covering the RAM's one-cycle registered-address read latency.
REQ-019 CHECK SHALL classify q_d; on an illegal byte it SHALL increment bad_count and, if this is the first illegal byte, load bad_index=k.
REQ-020 From CHECK, if k=MSG_LEN-1 the FSM SHALL go to DONE; otherwise it SHALL increment k and go to ADDR.
REQ-021 DONE SHALL assert finish for exactly one cycle, set key_valid=(bad_count==0) including the final CHECK result, and return to IDLE.
REQ-022 Each byte SHALL take 3 cycles; with start sampled at edge 0, finish SHALL be high in cycle 3*MSG_LEN+1, i.e. cycle 97 at the default MSG_LEN.
REQ-023 mem_req SHALL be high in ADDR, WAIT and CHECK only.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 key_valid, bad_index and bad_count SHALL hold their values from DONE until the next accepted start.
REQ-026 The index counter SHALL never wrap past MSG_LEN-1; address_d SHALL hold its last value outside ADDR.

Reset
REQ-027 reset_n=0 SHALL, asynchronously and at any time including mid-scan, force IDLE, k=0 and all outputs to 0.
REQ-028 After reset_n is released, the first rising edge with start=1 SHALL begin a fresh scan.

Configuration
REQ-029 When macro MSG_CHECK_EARLY_ABORT_EN is defined, CHECK SHALL go to DONE on the first illegal byte, giving bad_count=1 and finish in cycle 3*(k+1)+1.
REQ-030 When MSG_CHECK_EARLY_ABORT_EN is not defined, all MSG_LEN bytes SHALL always be scanned and bad_count SHALL be the full count (0..32).

Verification
REQ-031 All 32 bytes 0x61, start pulse -> finish in cycle 97, key_valid=1, bad_count=0, bad_index=0.
REQ-032 Byte 5=0x41, all others 0x20 -> without the macro: finish in cycle 97, key_valid=0, bad_index=5, bad_count=1; with the macro: finish in cycle 19, same values.
REQ-033 Bytes 0 and 31=0x7B, all others 0x7A, no macro -> key_valid=0, bad_index=0, bad_count=2.
REQ-034 Bytes 0..5 = 0x1F, 0x20, 0x60, 0x61, 0x7A, 0x7B, all others 0x20, no macro -> bad_count=3, bad_index=0.
REQ-035 reset_n low in cycle 40 of a scan -> all outputs 0 and FSM in IDLE; a new start then completes with finish in cycle 97 relative to that start.
REQ-036 start re-pulsed in cycle 10 of a scan -> ignored; exactly one finish pulse, in cycle 97.

Source files
------------

// File: rtl/msg_checker.sv
// msg_checker: scans MSG_LEN decrypted bytes from RAM and reports whether
// all of them are legal characters (space or 'a'..'z').
// Ports: clk, reset_n (async, active low), start; q_d RAM read data;
//   address_d RAM read address; mem_req RAM ownership request; busy;
//   finish one-cycle results-valid pulse; key_valid, bad_index, bad_count.
// Config: define MSG_CHECK_EARLY_ABORT_EN to stop at the first illegal byte.
module msg_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        q_d,
    output logic [ADDR_W-1:0] address_d,
    output logic              mem_req,
    output logic              busy,
    output logic              finish,
    output logic              key_valid,
    output logic [ADDR_W-1:0] bad_index,
    output logic [5:0]        bad_count
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] k;
    logic              legal;
    logic              last;
    logic              bad;

    assign legal = (q_d == 8'h20) ||
                   ((q_d >= 8'h61) && (q_d <= 8'h7A));
    assign last  = (k == ADDR_W'(MSG_LEN - 1));
    assign bad   = (state == CHECK) && !legal;

    // The index register doubles as the RAM address: it only changes on
    // the way into ADDR, so the address is stable through WAIT and CHECK.
    assign address_d = k;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        mem_req  = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ADDR;
            end
            ADDR: begin
                mem_req  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                mem_req  = 1'b1;
                state_nx = CHECK;
            end
            CHECK: begin
                mem_req = 1'b1;
`ifdef MSG_CHECK_EARLY_ABORT_EN
                if (last || !legal) state_nx = DONE;
                else                state_nx = ADDR;
`else
                if (last) state_nx = DONE;
                else      state_nx = ADDR;
`endif
            end
            DONE: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k         <= '0;
            bad_count <= '0;
            bad_index <= '0;
            key_valid <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                k         <= '0;
                bad_count <= '0;
                bad_index <= '0;
                key_valid <= 1'b0;
            end
            if (state == CHECK) begin
                if (bad) begin
                    bad_count <= bad_count + 6'd1;
                    if (bad_count == 6'd0) bad_index <= k;
                end
                // key_valid is settled on entry to DONE so it is already
                // correct while finish is high; it folds in this last byte.
                if (state_nx == DONE)
                    key_valid <= (bad_count == 6'd0) && legal;
                else
                    k <= k + 1'b1;
            end
        end
    end

endmodule
